// File: rtl/conv_mac_acc_if.sv
// conv_mac_acc_if -- bundle of the beat input and result output channels of
// conv_mac_acc.
//
// Handshake (both channels): a transfer happens on a rising clock edge where
// valid && ready are both 1. The producer holds its payload stable while
// valid=1 and ready=0. The consumer may drive ready independently of valid.
//
// Signals:
//   data2conv  KERNEL*KERNEL*N bits, tap i at [i*N +: N] (signed per tap)
//   w          KERNEL*KERNEL*M bits, tap i at [i*M +: M] (signed per tap)
//   bias       BIAS_W bits signed, used on the first beat of a group
//   in_valid   beat valid (producer -> block)
//   in_ready   block can accept a beat
//   d_out      OUT_W bits signed result
//   out_sat    d_out was clipped by saturation
//   out_valid  d_out valid
//   out_ready  consumer accepts d_out
// Modports: master = beat producer / result consumer, slave = the block.
interface conv_mac_acc_if #(
  parameter int KERNEL = 3,
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16
);
  logic [KERNEL*KERNEL*N-1:0] data2conv;
  logic [KERNEL*KERNEL*M-1:0] w;
  logic [BIAS_W-1:0]          bias;
  logic                       in_valid;
  logic                       in_ready;
  logic [OUT_W-1:0]           d_out;
  logic                       out_sat;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output data2conv, w, bias, in_valid, out_ready,
    input  in_ready, d_out, out_sat, out_valid
  );

  modport slave (
    input  data2conv, w, bias, in_valid, out_ready,
    output in_ready, d_out, out_sat, out_valid
  );
endinterface

// File: rtl/conv_mac_acc.sv
// conv_mac_acc -- convolution multiply-accumulate over C_IN channel beats.
//
// Each accepted beat carries KERNEL*KERNEL data taps and weights. Per beat the
// tap products are summed; C_IN consecutive beats form a group whose sums are
// added onto a signed bias. At the last beat of a group the total is passed
// through an optional ReLU and saturated to OUT_W bits.
//
// Pipeline (all stages advance together, all hold during a stall):
//   S0  input capture: taps, weights, bias, first/last tags
//   S1  per-tap signed products, N+M bits each
//   S2  sum of products, N+M+clog2(KERNEL*KERNEL) bits
//   S3  accumulator / post-processing into the output register
// A last beat accepted at edge E0 is visible on out_valid after edge E3.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  conv_mac_acc_if.slave (beat input + result output channels)
//
// KERNEL is expected to be 1, 3, 5 or 7; C_IN >= 1. The interface instance
// must use the same KERNEL/N/M/BIAS_W/OUT_W values as this module.
module conv_mac_acc #(
  parameter int KERNEL = 3,
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int C_IN   = 4,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16,
  parameter int RELU   = 0
) (
  input logic           clk,
  input logic           rst,
  conv_mac_acc_if.slave bus
);

  localparam int TAPS   = KERNEL * KERNEL;
  localparam int PROD_W = N + M;
  localparam int SUM_W  = PROD_W + $clog2(TAPS);
  localparam int ACC_W  = PROD_W + $clog2(TAPS * C_IN) + 1;
  localparam int CNT_W  = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_IN - 1);

  // ---------------------------------------------------------------------------
  // Flow control. A full output register that the consumer refuses freezes
  // the whole pipeline, so no beat ever needs to be dropped or buffered.
  // ---------------------------------------------------------------------------
  logic stall;
  logic accept;
  logic out_valid_q;

  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !rst && !stall;
  assign accept       = bus.in_valid && bus.in_ready;

  // Channel counter: position of the next accepted beat inside its group.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // S0: input capture
  // ---------------------------------------------------------------------------
  logic                     s0_valid;
  logic                     s0_first;
  logic                     s0_last;
  logic [TAPS*N-1:0]        s0_data;
  logic [TAPS*M-1:0]        s0_w;
  logic signed [BIAS_W-1:0] s0_bias;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
    end else if (!stall) begin
      s0_valid <= accept;
    end
  end

  // With C_IN=1 the counter is always 0 and equal to CNT_LAST, so every beat
  // is tagged both first and last.
  always_ff @(posedge clk) begin
    if (!stall && accept) begin
      s0_data  <= bus.data2conv;
      s0_w     <= bus.w;
      s0_bias  <= $signed(bus.bias);
      s0_first <= (cnt == '0);
      s0_last  <= (cnt == CNT_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // S1: per-tap signed products. Operands are sign-extended to the product
  // width first, so the truncated product is exact.
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod [TAPS];

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod[i] = PROD_W'($signed(s0_data[i*N +: N])) *
                PROD_W'($signed(s0_w[i*M +: M]));
    end
  end

  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_last;
  logic signed [PROD_W-1:0] s1_prod [TAPS];
  logic signed [BIAS_W-1:0] s1_bias;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= s0_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_prod  <= prod;
      s1_bias  <= s0_bias;
      s1_first <= s0_first;
      s1_last  <= s0_last;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: adder tree over the products, wide enough that it cannot overflow.
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum = sum + SUM_W'(s1_prod[i]);
    end
  end

  logic                     s2_valid;
  logic                     s2_first;
  logic                     s2_last;
  logic signed [SUM_W-1:0]  s2_sum;
  logic signed [BIAS_W-1:0] s2_bias;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s2_sum   <= sum;
      s2_bias  <= s1_bias;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: accumulate. The first beat of a group restarts from the bias, which
  // also makes any stale accumulator contents (e.g. after reset) irrelevant.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] relu_val;
  logic [OUT_W-1:0]        sat_val;
  logic                    sat_flag;

  always_comb begin
    acc_next = (s2_first ? ACC_W'(s2_bias) : acc) + ACC_W'(s2_sum);
  end

  always_comb begin
    relu_val = acc_next;
    if (RELU != 0 && acc_next[ACC_W-1]) begin
      relu_val = '0;
    end
  end

  // Saturation: the value fits in OUT_W bits exactly when all bits from
  // OUT_W-1 upward are copies of the sign bit.
  generate
    if (ACC_W > OUT_W) begin : g_sat
      logic [ACC_W-OUT_W:0] upper;
      assign upper = relu_val[ACC_W-1:OUT_W-1];

      always_comb begin
        sat_val  = relu_val[OUT_W-1:0];
        sat_flag = 1'b0;
        if (!((&upper) || !(|upper))) begin
          sat_flag = 1'b1;
          sat_val  = relu_val[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
    end else begin : g_nosat
      always_comb begin
        sat_val  = OUT_W'(relu_val);
        sat_flag = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!stall && s2_valid && !s2_last) begin
      acc <= acc_next;
    end
  end

  // Output register. When not stalled it either takes a newly completed
  // result (out_valid stays/becomes 1) or empties (a pending result was just
  // taken by the consumer, or nothing was there).
  logic [OUT_W-1:0] d_out_q;
  logic             out_sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
      out_sat_q   <= 1'b0;
    end else if (!stall) begin
      if (s2_valid && s2_last) begin
        out_valid_q <= 1'b1;
        d_out_q     <= sat_val;
        out_sat_q   <= sat_flag;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.d_out     = d_out_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv_mac_acc.sv
// tb_conv_mac_acc -- bench for conv_mac_acc.
// dut_a (KERNEL=3, C_IN=4, RELU=0) and dut_b (same, RELU=1) share one beat
// stream and one out_ready; dut_c (KERNEL=1, C_IN=1) runs a streaming case.
// Expected results come from a plain-arithmetic group model and are queued
// per DUT; a monitor pops and compares on every output handshake.
module tb_conv_mac_acc;
  localparam int K    = 3;
  localparam int N    = 8;
  localparam int M    = 8;
  localparam int C    = 4;
  localparam int BW   = 16;
  localparam int OW   = 16;
  localparam int TAPS = K * K;
  localparam longint OMAX = 32767;
  localparam longint OMIN = -32768;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drive signals ----------------
  logic [TAPS*N-1:0] drv_data;
  logic [TAPS*M-1:0] drv_w;
  logic [BW-1:0]     drv_bias;
  logic              in_valid;
  logic              out_ready;
  int                bp_mode;   // 0: ready=1, 1: random, 2: ready=0

  logic [N-1:0] c_data;
  logic [M-1:0] c_w;
  logic         c_valid;

  conv_mac_acc_if #(.KERNEL(K), .N(N), .M(M), .BIAS_W(BW), .OUT_W(OW)) if_a ();
  conv_mac_acc_if #(.KERNEL(K), .N(N), .M(M), .BIAS_W(BW), .OUT_W(OW)) if_b ();
  conv_mac_acc_if #(.KERNEL(1), .N(N), .M(M), .BIAS_W(BW), .OUT_W(OW)) if_c ();

  assign if_a.data2conv = drv_data;
  assign if_a.w         = drv_w;
  assign if_a.bias      = drv_bias;
  assign if_a.in_valid  = in_valid;
  assign if_a.out_ready = out_ready;
  assign if_b.data2conv = drv_data;
  assign if_b.w         = drv_w;
  assign if_b.bias      = drv_bias;
  assign if_b.in_valid  = in_valid;
  assign if_b.out_ready = out_ready;
  assign if_c.data2conv = c_data;
  assign if_c.w         = c_w;
  assign if_c.bias      = '0;
  assign if_c.in_valid  = c_valid;
  assign if_c.out_ready = 1'b1;

  conv_mac_acc #(.KERNEL(K), .N(N), .M(M), .C_IN(C), .BIAS_W(BW), .OUT_W(OW), .RELU(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  conv_mac_acc #(.KERNEL(K), .N(N), .M(M), .C_IN(C), .BIAS_W(BW), .OUT_W(OW), .RELU(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  conv_mac_acc #(.KERNEL(1), .N(N), .M(M), .C_IN(1), .BIAS_W(BW), .OUT_W(OW), .RELU(0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  // ---------------- scoreboard state ----------------
  logic [OW:0] exp_a[$];   // {sat, d_out}
  logic [OW:0] exp_b[$];
  int total;
  int bad;

  int beat_d [C][TAPS];
  int beat_w [C][TAPS];
  int g_bias;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Reference model: whole-group arithmetic, then ReLU, then clamp.
  function automatic void model_push();
    longint acc;
    longint v;
    logic   s;
    logic [OW-1:0] lo;
    acc = g_bias;
    for (int c = 0; c < C; c++)
      for (int t = 0; t < TAPS; t++)
        acc += longint'(beat_d[c][t]) * longint'(beat_w[c][t]);
    for (int r = 0; r < 2; r++) begin
      v = acc;
      s = 1'b0;
      if (r == 1 && v < 0) v = 0;
      if (v > OMAX) begin v = OMAX; s = 1'b1; end
      else if (v < OMIN) begin v = OMIN; s = 1'b1; end
      lo = v[OW-1:0];
      if (r == 0) exp_a.push_back({s, lo});
      else        exp_b.push_back({s, lo});
    end
  endfunction

  function automatic void fill_const(input int d, input int ww, input int b);
    for (int c = 0; c < C; c++)
      for (int t = 0; t < TAPS; t++) begin
        beat_d[c][t] = d;
        beat_w[c][t] = ww;
      end
    g_bias = b;
  endfunction

  function automatic void fill_random();
    for (int c = 0; c < C; c++)
      for (int t = 0; t < TAPS; t++) begin
        if ($urandom_range(0, 1) == 0) begin
          beat_d[c][t] = int'($urandom_range(0, 15)) - 8;
          beat_w[c][t] = int'($urandom_range(0, 15)) - 8;
        end else begin
          beat_d[c][t] = int'($urandom_range(0, 255)) - 128;
          beat_w[c][t] = int'($urandom_range(0, 255)) - 128;
        end
      end
    g_bias = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 511)) - 256
                                         : int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ---------------- driver ----------------
  // Drives at negedge, waits for in_ready, returns 1 time unit after the
  // accepting edge.
  task automatic send_beat(input int c, input logic [BW-1:0] b);
    int guard;
    int x;
    @(negedge clk);
    for (int t = 0; t < TAPS; t++) begin
      x = beat_d[c][t];
      drv_data[t*N +: N] = x[N-1:0];
      x = beat_w[c][t];
      drv_w[t*M +: M] = x[M-1:0];
    end
    drv_bias = b;
    in_valid = 1'b1;
    guard = 0;
    while (!if_a.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) fail_now("send_beat_wait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Bias is presented correctly only on the first beat; later beats carry
  // junk there, which the block must ignore.
  task automatic send_group();
    int b;
    model_push();
    for (int c = 0; c < C; c++) begin
      b = (c == 0) ? g_bias : int'($urandom);
      send_beat(c, b[BW-1:0]);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) fail_now("drain");
    repeat (4) @(negedge clk);
  endtask

  // ---------------- out_ready generator ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [OW:0]   e;
    logic [OW-1:0] held_a;
    logic [OW-1:0] held_b;
    logic          held_sa;
    logic          held_sb;
    bit            holding;
    holding = 0;
    forever begin
      @(negedge clk);
      if (!rst && if_a.out_valid && if_a.out_ready) begin
        if (exp_a.size() == 0) fail_now("a_unexpected_result");
        else begin
          e = exp_a.pop_front();
          check("a_d_out", $signed(if_a.d_out), $signed(e[OW-1:0]));
          check("a_out_sat", if_a.out_sat, e[OW]);
        end
      end
      if (!rst && if_b.out_valid && if_b.out_ready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected_result");
        else begin
          e = exp_b.pop_front();
          check("b_d_out", $signed(if_b.d_out), $signed(e[OW-1:0]));
          check("b_out_sat", if_b.out_sat, e[OW]);
        end
      end
      if (!rst && if_a.out_valid && !if_a.out_ready) begin
        if (holding) begin
          check("a_stall_d_out_stable", if_a.d_out, held_a);
          check("a_stall_sat_stable", if_a.out_sat, held_sa);
          check("b_stall_d_out_stable", if_b.d_out, held_b);
          check("b_stall_sat_stable", if_b.out_sat, held_sb);
        end
        held_a  = if_a.d_out;
        held_sa = if_a.out_sat;
        held_b  = if_b.d_out;
        held_sb = if_b.out_sat;
        holding = 1;
      end else begin
        holding = 0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int g;
    total    = 0;
    bad      = 0;
    bp_mode  = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    drv_data = '0;
    drv_w    = '0;
    drv_bias = '0;
    c_valid  = 1'b0;
    c_data   = '0;
    c_w      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_in_ready", if_a.in_ready, 0);
    check("rst_a_out_valid", if_a.out_valid, 0);
    check("rst_a_d_out", if_a.d_out, 0);
    check("rst_a_out_sat", if_a.out_sat, 0);
    check("rst_c_in_ready", if_c.in_ready, 0);
    check("rst_c_out_valid", if_c.out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_a_in_ready", if_a.in_ready, 1);

    // All ones: 36, with latency measured from the last accepted beat
    fill_const(1, 1, 0);
    send_group();
    n = 0;
    while (!if_a.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_cycles", n, 3);
    drain();

    // Deep negative: raw -585216 clamps (RELU=0) or becomes 0 (RELU=1)
    fill_const(-128, 127, 0);
    send_group();
    drain();

    // Negative bias: -4 / 0
    fill_const(1, 1, -40);
    send_group();
    drain();

    // Backpressure: out_ready held low while beats keep arriving
    bp_mode = 2;
    @(posedge clk);
    #2;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          fill_random();
          send_group();
        end
      end
      begin
        g = 0;
        while (!if_a.out_valid && g < 200) begin
          @(negedge clk);
          g++;
        end
        if (g >= 200) fail_now("bp_first_result");
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_in_ready_low", if_a.in_ready, 0);
          check("bp_out_valid_held", if_a.out_valid, 1);
        end
        bp_mode = 0;
      end
    join
    drain();

    // Reset mid-group: 2 beats discarded, then a clean group of ones
    fill_const(1, 1, 0);
    send_beat(0, '0);
    send_beat(1, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", if_a.in_ready, 0);
    check("midrst_out_valid", if_a.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    fill_const(1, 1, 0);
    send_group();
    drain();
    repeat (10) @(negedge clk);

    // Randomized groups with random backpressure and input gaps
    bp_mode = 1;
    for (int k = 0; k < 25; k++) begin
      fill_random();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_group();
    end
    drain();
    bp_mode = 0;
    drain();

    // K=1, C_IN=1 streaming: 3 * -5 every cycle after the fill
    @(negedge clk);
    c_data  = 8'd3;
    c_w     = 8'hFB;
    c_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check("c_in_ready", if_c.in_ready, 1);
      if (k < 4) begin
        check("c_fill_out_valid", if_c.out_valid, 0);
      end else begin
        check("c_out_valid", if_c.out_valid, 1);
        check("c_d_out", $signed(if_c.d_out), -15);
        check("c_out_sat", if_c.out_sat, 0);
      end
    end
    c_valid = 1'b0;
    repeat (5) @(negedge clk);

    check("exp_a_left", exp_a.size(), 0);
    check("exp_b_left", exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv_mac_acc.md
CONV_MAC_ACC -- requirements
Module: conv_mac_acc

Interface
REQ-001 The block SHALL have parameter KERNEL, default 3, giving the kernel side length; legal values are 1, 3, 5 and 7.
REQ-002 The block SHALL have parameter N, default 8, giving the signed data width.
REQ-003 The block SHALL have parameter M, default 8, giving the signed weight width.
REQ-004 The block SHALL have parameter C_IN, default 4, giving the number of input-channel beats accumulated per result; C_IN >= 1.
REQ-005 The block SHALL have parameter BIAS_W, default 16, giving the signed bias width.
REQ-006 The block SHALL have parameter OUT_W, default 16, giving the signed output width.
REQ-007 The block SHALL have parameter RELU, default 0, where 1 enables ReLU on the output.
REQ-008 The block SHALL have port clk, input, 1 bit: clock; all logic is clocked on the rising edge.
REQ-009 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-010 The block SHALL have port data2conv, input, KERNEL*KERNEL*N bits: tap i occupies bits [i*N +: N].
REQ-011 The block SHALL have port w, input, KERNEL*KERNEL*M bits: tap i occupies bits [i*M +: M].
REQ-012 The block SHALL have port bias, input, BIAS_W bits: signed bias, sampled on the first beat of each group.
REQ-013 The block SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-014 The block SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-015 The block SHALL have port d_out, output, OUT_W bits: signed result.
REQ-016 The block SHALL have port out_sat, output, 1 bit: d_out was clipped by saturation.
REQ-017 The block SHALL have port out_valid, output, 1 bit: d_out is valid.
REQ-018 The block SHALL have port out_ready, input, 1 bit: the consumer accepts d_out.

Function
REQ-019 A beat SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-020 A channel counter SHALL count accepted beats from 0 to C_IN-1 and wrap to 0.
REQ-021 A beat accepted at count 0 SHALL be tagged first; a beat accepted at count C_IN-1 SHALL be tagged last; with C_IN=1 every beat is both.
REQ-022 Stage S1 SHALL register the KERNEL*KERNEL signed products w[i]*data2conv[i], each N+M bits and sign-correct, together with the valid, first and last tags.
REQ-023 Stage S2 SHALL register the signed sum of all S1 products, sign-extended to N+M+clog2(KERNEL*KERNEL) bits, so the sum never overflows.
REQ-024 Stage S3 SHALL hold an accumulator ACC of ACC_W = N+M+clog2(KERNEL*KERNEL*C_IN)+1 bits that never overflows.
REQ-025 On a valid S2 beat, S3 SHALL compute acc_next = (first ? sign-extended bias : ACC) + S2 sum.
REQ-026 If the S2 beat is not last, S3 SHALL load ACC with acc_next.
REQ-027 If the S2 beat is last, S3 SHALL post-process acc_next into the output register, set out_valid=1, and leave ACC don't-care.
REQ-028 Post-processing SHALL first apply ReLU when RELU=1 (a negative value becomes 0), then saturate to the signed OUT_W range.
REQ-029 out_sat SHALL be 1 when saturation changed the value, else 0.
REQ-030 Latency SHALL be exactly 3 cycles: the last beat accepted at edge E0 gives out_valid=1 after edge E3, with no stall.
REQ-031 A stall SHALL be defined as out_valid && !out_ready.
REQ-032 During a stall, in_ready SHALL be 0 and S1, S2, S3, the counter and the output register SHALL all hold.
REQ-033 When there is no stall, in_ready SHALL be 1.
REQ-034 When out_valid && out_ready and a new last beat completes in S3 in the same cycle, the new result SHALL load and out_valid SHALL stay 1.
REQ-035 When out_valid && out_ready and no result completes, out_valid SHALL go to 0.
REQ-036 d_out and out_sat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-037 With continuous input and out_ready=1, throughput SHALL be one result per C_IN cycles.

Reset
REQ-038 While rst=1, the channel counter, all stage valid tags, out_valid, d_out and out_sat SHALL be 0.
REQ-039 While rst=1, in_ready SHALL be 0.
REQ-040 A reset mid-group SHALL discard the partial accumulation, and the first beat after reset SHALL be treated as first.
REQ-041 Product, sum and ACC data registers need no reset.

Verification
REQ-042 Case K=3, N=M=8, C_IN=4, OUT_W=16: all taps data=1, w=1, bias=0, 4 beats -> d_out=36, out_sat=0, out_valid 3 cycles after beat 4.
REQ-043 Case data=-128, w=127 on all taps, 4 beats, bias=0: with RELU=0 -> d_out=-32768 and out_sat=1 (raw -585216); with RELU=1 -> d_out=0 and out_sat=0.
REQ-044 Case bias=-40, data=1, w=1, 4 beats: with RELU=0 -> d_out=-4; with RELU=1 -> d_out=0.
REQ-045 Case backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, d_out stable; on release, results arrive in order with none lost or duplicated.
REQ-046 Case rst pulsed after 2 beats of a group, then 4 clean beats of ones -> a single d_out=36 and no stale result.
REQ-047 Case K=1, C_IN=1, continuous in_valid=1, out_ready=1, data=3, w=-5 -> d_out=-15 every cycle after a 3-cycle fill.
